// File: rtl/motor_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
// Shared definitions for the motor PWM driver:
//   cmd_e        - decoded per-motor command (COAST / FWD / REV)
//   state_e      - per-motor H-bridge FSM state encoding
//   decode_cmd   - (hi, lo, inhibit) request pins -> cmd_e; 11 is treated as COAST
//   cmd_to_state - target FSM state for a command when leaving IDLE or DEAD
//   duty_base    - speed select -> duty in 256ths of a period (64/128/192/256)
// -----------------------------------------------------------------------------
package motor_pkg;

  typedef enum logic [1:0] {
    CMD_COAST = 2'd0,
    CMD_FWD   = 2'd1,
    CMD_REV   = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } state_e;

  // Forward is turned into coast while the obstacle flag is set; reverse is
  // always allowed so the robot can back away from the wall.
  function automatic cmd_e decode_cmd(input logic hi, input logic lo,
                                      input logic inhibit_fwd);
    cmd_e c;
    case ({hi, lo})
      2'b10:   c = inhibit_fwd ? CMD_COAST : CMD_FWD;
      2'b01:   c = CMD_REV;
      default: c = CMD_COAST;
    endcase
    return c;
  endfunction

  function automatic state_e cmd_to_state(input cmd_e c);
    state_e s;
    case (c)
      CMD_FWD: s = ST_FWD;
      CMD_REV: s = ST_REV;
      default: s = ST_IDLE;
    endcase
    return s;
  endfunction

  // 256 is one wider than the 8-bit counter so that 100% keeps count < duty true.
  function automatic logic [8:0] duty_base(input logic [1:0] speed);
    logic [8:0] d;
    case (speed)
      2'd0:    d = 9'd64;
      2'd1:    d = 9'd128;
      2'd2:    d = 9'd192;
      2'd3:    d = 9'd256;
      default: d = 9'd64;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hbridge_deadtime.sv
// -----------------------------------------------------------------------------
// hbridge_deadtime
// One motor's H-bridge leg control: registers the decoded command, runs the
// IDLE/FWD/REV/DEAD state machine with a break-before-make dead counter, and
// registers the two bridge pins gated by the shared PWM enable.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   cmd_hi_i        forward request pin
//   cmd_lo_i        reverse request pin
//   inhibit_fwd_i   synchronised obstacle flag; forces FWD to decode as COAST
//   pwm_on_i        PWM enable for the current counter phase
//   out_hi_o        registered forward bridge pin
//   out_lo_o        registered reverse bridge pin
// -----------------------------------------------------------------------------
module hbridge_deadtime
  import motor_pkg::*;
#(
  parameter int DEAD_CYCLES = 50,
  parameter int DEAD_W      = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cmd_hi_i,
  input  logic cmd_lo_i,
  input  logic inhibit_fwd_i,
  input  logic pwm_on_i,
  output logic out_hi_o,
  output logic out_lo_o
);

  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  cmd_e              cmd_q, cmd_d;
  state_e            state_q, state_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic              out_hi_q, out_hi_d;
  logic              out_lo_q, out_lo_d;

  assign cmd_d = decode_cmd(cmd_hi_i, cmd_lo_i, inhibit_fwd_i);

  // State register: command stage, FSM state, dead counter and bridge pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q    <= CMD_COAST;
      state_q  <= ST_IDLE;
      dead_q   <= '0;
      out_hi_q <= 1'b0;
      out_lo_q <= 1'b0;
    end else begin
      cmd_q    <= cmd_d;
      state_q  <= state_d;
      dead_q   <= dead_d;
      out_hi_q <= out_hi_d;
      out_lo_q <= out_lo_d;
    end
  end

  // Next-state logic: a direct reversal goes through DEAD, a coast never does.
  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    case (state_q)
      ST_IDLE: begin
        state_d = cmd_to_state(cmd_q);
      end
      ST_FWD: begin
        if (cmd_q == CMD_REV) begin
          state_d = ST_DEAD;
          dead_d  = DEAD_LOAD;
        end else if (cmd_q == CMD_FWD) begin
          state_d = ST_FWD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REV: begin
        if (cmd_q == CMD_FWD) begin
          state_d = ST_DEAD;
          dead_d  = DEAD_LOAD;
        end else if (cmd_q == CMD_REV) begin
          state_d = ST_REV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DEAD: begin
        // The window always runs out fully; the command is only looked at
        // on the final cycle, so a flip-back cannot shorten it.
        if (dead_q == '0) begin
          state_d = cmd_to_state(cmd_q);
        end else begin
          dead_d = dead_q - DEAD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        dead_d  = '0;
      end
    endcase
  end

  // Output logic: pins follow the next state so command-to-pin is two clocks.
  always_comb begin
    out_hi_d = (state_d == ST_FWD) & pwm_on_i;
    out_lo_d = (state_d == ST_REV) & pwm_on_i;
  end

  assign out_hi_o = out_hi_q;
  assign out_lo_o = out_lo_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// motor_pwm_driver
// Drives the left/right H-bridge GPIO pins from the control block's direction
// requests, adding speed-dependent PWM, break-before-make dead time on every
// direction reversal and forward inhibit from the ultrasonic wall flag.
// Ports:
//   clk                    system clock
//   reset_n                asynchronous active-low reset
//   l_cmd_hi / l_cmd_lo    left motor forward / reverse request
//   r_cmd_hi / r_cmd_lo    right motor forward / reverse request
//   speed[1:0]             duty select 25/50/75/100 %
//   wall_sense             obstacle flag, asynchronous to clk
//   l_out_hi / l_out_lo    left bridge pins
//   r_out_hi / r_out_lo    right bridge pins
//   blocked                a forward request is being suppressed
// -----------------------------------------------------------------------------
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEAD_CYCLES = 50,
  parameter int DEAD_W      = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       l_cmd_hi,
  input  logic       l_cmd_lo,
  input  logic       r_cmd_hi,
  input  logic       r_cmd_lo,
  input  logic [1:0] speed,
  input  logic       wall_sense,
  output logic       l_out_hi,
  output logic       l_out_lo,
  output logic       r_out_hi,
  output logic       r_out_lo,
  output logic       blocked
);

  localparam int               DUTY_W     = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W:0]   DUTY_RESET = DUTY_W'(9'd64) << (CNT_W - 8);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   duty_q, duty_d;
  logic [CNT_W:0]   duty_scaled;
  logic             ws_meta_q, ws_sync_q;
  logic             blocked_q, blocked_d;
  logic             pwm_on;
  logic             l_fwd_req, r_fwd_req;

  assign duty_scaled = DUTY_W'(duty_base(speed)) << (CNT_W - 8);
  assign pwm_on      = {1'b0, count_q} < duty_q;
  assign l_fwd_req   = l_cmd_hi & ~l_cmd_lo;
  assign r_fwd_req   = r_cmd_hi & ~r_cmd_lo;

  // PWM counter, period-aligned duty latch, wall synchroniser, blocked flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      duty_q    <= DUTY_RESET;
      ws_meta_q <= 1'b0;
      ws_sync_q <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      duty_q    <= duty_d;
      ws_meta_q <= wall_sense;
      ws_sync_q <= ws_meta_q;
      blocked_q <= blocked_d;
    end
  end

  // Next values: duty only reloads as the count wraps, so no period is split.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (count_q == CNT_MAX) begin
      duty_d = duty_scaled;
    end else begin
      duty_d = duty_q;
    end
    blocked_d = ws_sync_q & (l_fwd_req | r_fwd_req);
  end

  hbridge_deadtime #(
    .DEAD_CYCLES (DEAD_CYCLES),
    .DEAD_W      (DEAD_W)
  ) u_left (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_hi_i      (l_cmd_hi),
    .cmd_lo_i      (l_cmd_lo),
    .inhibit_fwd_i (ws_sync_q),
    .pwm_on_i      (pwm_on),
    .out_hi_o      (l_out_hi),
    .out_lo_o      (l_out_lo)
  );

  hbridge_deadtime #(
    .DEAD_CYCLES (DEAD_CYCLES),
    .DEAD_W      (DEAD_W)
  ) u_right (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_hi_i      (r_cmd_hi),
    .cmd_lo_i      (r_cmd_lo),
    .inhibit_fwd_i (ws_sync_q),
    .pwm_on_i      (pwm_on),
    .out_hi_o      (r_out_hi),
    .out_lo_o      (r_out_lo)
  );

  assign blocked = blocked_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_motor_pwm_driver
// Directed scenarios followed by a randomized soak. A behavioural model pushes
// the expected pin vector for every clock into a scoreboard queue; a separate
// monitor pops and compares on the falling edge and also checks the hi/lo
// overlap and dead-time invariants directly on the pins.
// -----------------------------------------------------------------------------
module tb_motor_pwm_driver;

  localparam int DEAD = 50;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       l_cmd_hi = 1'b0, l_cmd_lo = 1'b0, r_cmd_hi = 1'b0, r_cmd_lo = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       wall_sense = 1'b0;
  logic       l_out_hi, l_out_lo, r_out_hi, r_out_lo, blocked;

  motor_pwm_driver #(.CNT_W(8), .DEAD_CYCLES(50), .DEAD_W(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .l_cmd_hi   (l_cmd_hi),
    .l_cmd_lo   (l_cmd_lo),
    .r_cmd_hi   (r_cmd_hi),
    .r_cmd_lo   (r_cmd_lo),
    .speed      (speed),
    .wall_sense (wall_sense),
    .l_out_hi   (l_out_hi),
    .l_out_lo   (l_out_lo),
    .r_out_hi   (r_out_hi),
    .r_out_lo   (r_out_lo),
    .blocked    (blocked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0] pins;   // {l_hi, l_lo, r_hi, r_lo, blocked}
    logic [1:0] idle;   // motor m is coasting after this edge
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d..%0d at t=%0t", name, act, lo, hi, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Works in absolute edge numbers since reset release: PWM phase is the edge
  // number mod 256, the synchronised wall flag is the input from two edges ago,
  // the motor acts on the request seen one edge earlier, and a reversal keeps
  // the motor unpowered for DEAD edges before it follows the request again.
  int unsigned cyc;
  int          period_duty;
  bit          w1, w2;
  int          prev_req[2];
  int          mode[2];        // 0 coast, 1 forward, 2 reverse, 3 reversing
  int unsigned rev_end[2];

  function automatic int request(input bit hi, input bit lo, input bit inhibit);
    if (hi && !lo) return inhibit ? 0 : 1;
    if (lo && !hi) return 2;
    return 0;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      cyc = 0; period_duty = 64; w1 = 1'b0; w2 = 1'b0;
      for (int m = 0; m < 2; m++) begin
        prev_req[m] = 0; mode[m] = 0; rev_end[m] = 0;
      end
      sb_q.delete();
    end else begin
      exp_t e;
      bit   pwm, ws;
      int   req[2];
      int   c;
      pwm = (int'(cyc % 256) < period_duty);
      ws  = w2;
      req[0] = request(l_cmd_hi, l_cmd_lo, ws);
      req[1] = request(r_cmd_hi, r_cmd_lo, ws);
      for (int m = 0; m < 2; m++) begin
        c = prev_req[m];
        case (mode[m])
          0: mode[m] = c;
          1: if (c == 0) mode[m] = 0;
             else if (c == 2) begin mode[m] = 3; rev_end[m] = cyc + DEAD; end
          2: if (c == 0) mode[m] = 0;
             else if (c == 1) begin mode[m] = 3; rev_end[m] = cyc + DEAD; end
          default: if (cyc == rev_end[m]) mode[m] = c;
        endcase
        prev_req[m] = req[m];
      end
      e.pins[4] = (mode[0] == 1) && pwm;
      e.pins[3] = (mode[0] == 2) && pwm;
      e.pins[2] = (mode[1] == 1) && pwm;
      e.pins[1] = (mode[1] == 2) && pwm;
      e.pins[0] = ws && ((l_cmd_hi && !l_cmd_lo) || (r_cmd_hi && !r_cmd_lo));
      e.idle[0] = (mode[0] == 0);
      e.idle[1] = (mode[1] == 0);
      if (cyc % 256 == 255) period_duty = 64 * (int'(speed) + 1);
      w2 = w1; w1 = wall_sense;
      cyc++;
      sb_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  int  last_dir[2];
  int  gap[2];
  bit  idle_seen[2];

  initial forever begin
    logic [4:0] act;
    exp_t       e;
    bit         hi, lo;
    @(negedge clk);
    act = {l_out_hi, l_out_lo, r_out_hi, r_out_lo, blocked};
    if (!reset_n) begin
      check("reset_pins", act, 0);
      for (int m = 0; m < 2; m++) begin
        last_dir[m] = 0; gap[m] = 0; idle_seen[m] = 1'b1;
      end
    end else if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("pins", act, e.pins);
      for (int m = 0; m < 2; m++) begin
        hi = (m == 0) ? act[4] : act[2];
        lo = (m == 0) ? act[3] : act[1];
        check("overlap", hi & lo, 0);
        if (e.idle[m]) idle_seen[m] = 1'b1;
        if (hi || lo) begin
          if (last_dir[m] != 0 && last_dir[m] != (hi ? 1 : 2) && !idle_seen[m])
            check_range("deadtime", gap[m], DEAD, 1000000);
          last_dir[m] = hi ? 1 : 2; gap[m] = 0; idle_seen[m] = 1'b0;
        end else begin
          gap[m]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_cmd(input bit lh, input bit ll, input bit rh, input bit rl);
    l_cmd_hi = lh; l_cmd_lo = ll; r_cmd_hi = rh; r_cmd_lo = rl;
  endtask

  // Apply reversal beforehand; counts both-low samples from hi falling until
  // either pin rises. Optionally flips the left request back to FWD mid-window.
  task automatic measure_gap(input int flip_at, output int g);
    int w;
    w = 0;
    while (l_out_hi && w < 10) begin tick(1); w++; end
    g = (l_out_hi || l_out_lo) ? 0 : 1;
    while (!(l_out_hi || l_out_lo) && g < 300) begin
      if (g == flip_at) set_cmd(1'b1, 1'b0, r_cmd_hi, r_cmd_lo);
      tick(1);
      if (!(l_out_hi || l_out_lo)) g++;
    end
  endtask

  initial begin
    int cnt, g, n, acc;
    set_cmd(1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);
    reset_n = 1'b1;

    // Duty per speed with left FWD held
    set_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      speed = 2'(s);
      tick(600);
      cnt = 0;
      repeat (256) begin tick(1); cnt += int'(l_out_hi); end
      check("duty", cnt, 64 * (s + 1));
    end

    // Asynchronous reset mid-PWM, then 50% after release
    speed = 2'd1;
    tick(300);
    @(posedge clk); #2 reset_n = 1'b0; #1;
    check("reset_async", {l_out_hi, l_out_lo, r_out_hi, r_out_lo, blocked}, 0);
    tick(3);
    reset_n = 1'b1;
    tick(600);
    cnt = 0;
    repeat (256) begin tick(1); cnt += int'(l_out_hi); end
    check("duty_after_reset", cnt, 128);

    // Reversal FWD -> REV at 100%
    speed = 2'd3;
    tick(600);
    set_cmd(1'b0, 1'b1, 1'b0, 1'b0);
    measure_gap(0, g);
    check("rev_gap", g, DEAD);
    check("rev_lo_rises", l_out_lo, 1);

    // Flip back to FWD inside the dead window
    set_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    tick(120);
    set_cmd(1'b0, 1'b1, 1'b0, 1'b0);
    measure_gap(10, g);
    check("flip_gap", g, DEAD);
    check("flip_hi_rises", l_out_hi, 1);

    // Coast for one cycle, then reverse: no dead time
    tick(20);
    set_cmd(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    set_cmd(1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!l_out_lo && n < 10) begin tick(1); n++; end
    check_range("coast_latency", n, 1, 3);
    check("coast_lo", l_out_lo, 1);

    // Wall inhibit
    set_cmd(1'b1, 1'b0, 1'b1, 1'b0);
    tick(100);
    wall_sense = 1'b1;
    tick(4);
    check("wall_pins", {l_out_hi, r_out_hi}, 0);
    check("wall_blocked", blocked, 1);
    set_cmd(1'b0, 1'b1, 1'b1, 1'b0);
    tick(3);
    check("wall_rev", l_out_lo, 1);
    wall_sense = 1'b0;
    tick(5);
    check("wall_resume", r_out_hi, 1);
    check("wall_unblocked", blocked, 0);

    // Illegal 11 on right
    set_cmd(1'b0, 1'b0, 1'b1, 1'b1);
    tick(5);
    acc = 0;
    repeat (10) begin tick(1); acc += int'(r_out_hi) + int'(r_out_lo); end
    check("illegal_r", acc, 0);

    // Randomized soak
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        l_cmd_hi = 1'($urandom_range(0, 1)); l_cmd_lo = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 39) == 0) begin
        r_cmd_hi = 1'($urandom_range(0, 1)); r_cmd_lo = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 299) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) wall_sense = ~wall_sense;
      tick(1);
    end

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
